// File: rtl/mouse_pkg.sv
// Shared constants and types for the PS/2 mouse position tracker.
package mouse_pkg;

   localparam int XSGN    = 4;
   localparam int YSGN    = 5;
   localparam int XOVF    = 6;
   localparam int YOVF    = 7;
   localparam int BTN_LSB = 0;
   localparam int BTN_W   = 3;

   localparam int DEFAULT_LIMIT_X = 640;
   localparam int DEFAULT_LIMIT_Y = 480;
   localparam int MIN_LIMIT       = 2;

   // A flagged overflow means the device lost the true count; assume the extreme.
   localparam logic signed [8:0] OVF_POS = 9'h0FF;
   localparam logic signed [8:0] OVF_NEG = 9'h100;

   typedef logic [1:0] shift_t;

endpackage

// File: rtl/mouse_axis_update.sv
// One movement axis: delta decode/scale in stage 1, position add with clamp/wrap in stage 2.
module mouse_axis_update
   import mouse_pkg::*;
#(
   parameter int POS_W     = 10,
   parameter int DEF_LIMIT = 640
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             flush,
   input  logic             fire,
   input  logic [POS_W-1:0] limit,
   input  logic [POS_W-1:0] loadLimit,
   input  logic             wrap,
   input  shift_t           shift,
   input  logic             invert,
   input  logic             ovf,
   input  logic             sgn,
   input  logic [7:0]       rawDelta,
   output logic [POS_W-1:0] pos
);

   localparam int SUM_W = POS_W + 4;

   logic signed [8:0]       delta9;
   logic signed [SUM_W-1:0] deltaExt;
   logic signed [SUM_W-1:0] deltaScaled;
   logic signed [SUM_W-1:0] delta_p1;
   logic signed [SUM_W-1:0] sum;

   // Wrap applies a single correction; anything still outside the range is clamped.
   function automatic logic [POS_W-1:0] fitRange(input logic signed [SUM_W-1:0] s,
                                                 input logic [POS_W-1:0]       lim,
                                                 input logic                   wrapMode);
      logic signed [SUM_W-1:0] limS;
      logic signed [SUM_W-1:0] v;
      limS = signed'({4'b0000, lim});
      v    = s;
      if (wrapMode) begin
         if (v[SUM_W-1])
            v = v + limS;
         else if (v >= limS)
            v = v - limS;
      end
      if (v[SUM_W-1])
         v = '0;
      else if (v > limS - SUM_W'(1))
         v = limS - SUM_W'(1);
      return v[POS_W-1:0];
   endfunction

   always_comb begin
      delta9 = signed'({sgn, rawDelta});
      if (ovf)
         delta9 = sgn ? OVF_NEG : OVF_POS;
      deltaExt    = SUM_W'(delta9);
      deltaScaled = deltaExt <<< shift;
      if (invert)
         deltaScaled = -deltaScaled;
   end

   // Stage 1 -> 2 boundary
   always_ff @(posedge CLK) begin
      delta_p1 <= deltaScaled;
   end

   assign sum = signed'({4'b0000, pos}) + delta_p1;

   // Stage 2 -> output boundary
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         pos <= POS_W'(DEF_LIMIT / 2);
      else if (flush)
         pos <= loadLimit >> 1;
      else if (fire)
         pos <= fitRange(sum, limit, wrap);
   end

endmodule

// File: rtl/mouse_position_tracker.sv
// Turns raw PS/2 packets into clamped/wrapped cursor coordinates, wheel count,
// button edges and a valid/ready update handshake with overrun detection.
module mouse_position_tracker
   import mouse_pkg::*;
#(
   parameter int POS_W       = 10,
   parameter int DEF_LIMIT_X = DEFAULT_LIMIT_X,
   parameter int DEF_LIMIT_Y = DEFAULT_LIMIT_Y,
   parameter int WHEEL_EN    = 0,
   parameter int Z_W         = 8
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    PKT_VALID,
   input  logic [7:0]              PKT_STATUS,
   input  logic [7:0]              PKT_DX,
   input  logic [7:0]              PKT_DY,
   input  logic [7:0]              PKT_DZ,
   input  logic                    CFG_LOAD,
   input  logic [POS_W-1:0]        CFG_LIMIT_X,
   input  logic [POS_W-1:0]        CFG_LIMIT_Y,
   input  logic                    CFG_WRAP,
   input  logic [1:0]              CFG_SHIFT,
   input  logic                    CFG_INVERT_Y,
   input  logic                    OVERRUN_CLR,
   output logic [POS_W-1:0]        MOUSE_X,
   output logic [POS_W-1:0]        MOUSE_Y,
   output logic signed [Z_W-1:0]   MOUSE_Z,
   output logic [BTN_W-1:0]        BUTTONS,
   output logic [BTN_W-1:0]        BTN_PRESS,
   output logic [BTN_W-1:0]        BTN_RELEASE,
   output logic                    UPD_VALID,
   input  logic                    UPD_READY,
   output logic                    OVERRUN
);

   localparam int ZS_W = Z_W + 1;

   logic [POS_W-1:0]    limitX;
   logic [POS_W-1:0]    limitY;
   logic [POS_W-1:0]    loadLimitX;
   logic [POS_W-1:0]    loadLimitY;
   logic                wrapMode;
   shift_t              shiftAmt;
   logic                invertY;
   logic                vld_p1;
   logic                fire;
   logic [BTN_W-1:0]    btn_p1;
   logic signed [3:0]   dz_p1;
   logic                unusedBits;

   function automatic logic [POS_W-1:0] floorLimit(input logic [POS_W-1:0] lim);
      return (lim < POS_W'(MIN_LIMIT)) ? POS_W'(MIN_LIMIT) : lim;
   endfunction

   function automatic logic signed [Z_W-1:0] satAddZ(input logic signed [Z_W-1:0] z,
                                                     input logic signed [3:0]     dz);
      logic signed [ZS_W-1:0] s;
      s = ZS_W'(z) + ZS_W'(dz);
      if (s[ZS_W-1] != s[Z_W-1])
         return s[ZS_W-1] ? {1'b1, {(Z_W-1){1'b0}}} : {1'b0, {(Z_W-1){1'b1}}};
      return s[Z_W-1:0];
   endfunction

   assign loadLimitX = floorLimit(CFG_LIMIT_X);
   assign loadLimitY = floorLimit(CFG_LIMIT_Y);
   assign unusedBits = ^{PKT_DZ[7:4], PKT_STATUS[3]};

   // A config load in the same cycle kills whatever packet would otherwise advance.
   assign fire = vld_p1 & ~CFG_LOAD;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         limitX   <= POS_W'(DEF_LIMIT_X);
         limitY   <= POS_W'(DEF_LIMIT_Y);
         wrapMode <= 1'b0;
         shiftAmt <= '0;
         invertY  <= 1'b0;
      end else if (CFG_LOAD) begin
         limitX   <= loadLimitX;
         limitY   <= loadLimitY;
         wrapMode <= CFG_WRAP;
         shiftAmt <= CFG_SHIFT;
         invertY  <= CFG_INVERT_Y;
      end
   end

   // Stage 0 -> 1 boundary
   always_ff @(posedge CLK) begin
      btn_p1 <= PKT_STATUS[BTN_LSB +: BTN_W];
      dz_p1  <= signed'(PKT_DZ[3:0]);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= PKT_VALID & ~CFG_LOAD;
   end

   mouse_axis_update #(.POS_W(POS_W), .DEF_LIMIT(DEF_LIMIT_X)) axisX (
      .CLK       (CLK),
      .RESET     (RESET),
      .flush     (CFG_LOAD),
      .fire      (fire),
      .limit     (limitX),
      .loadLimit (loadLimitX),
      .wrap      (wrapMode),
      .shift     (shiftAmt),
      .invert    (1'b0),
      .ovf       (PKT_STATUS[XOVF]),
      .sgn       (PKT_STATUS[XSGN]),
      .rawDelta  (PKT_DX),
      .pos       (MOUSE_X)
   );

   mouse_axis_update #(.POS_W(POS_W), .DEF_LIMIT(DEF_LIMIT_Y)) axisY (
      .CLK       (CLK),
      .RESET     (RESET),
      .flush     (CFG_LOAD),
      .fire      (fire),
      .limit     (limitY),
      .loadLimit (loadLimitY),
      .wrap      (wrapMode),
      .shift     (shiftAmt),
      .invert    (invertY),
      .ovf       (PKT_STATUS[YOVF]),
      .sgn       (PKT_STATUS[YSGN]),
      .rawDelta  (PKT_DY),
      .pos       (MOUSE_Y)
   );

   // Stage 1 -> 2 boundary
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         MOUSE_Z     <= '0;
         BUTTONS     <= '0;
         BTN_PRESS   <= '0;
         BTN_RELEASE <= '0;
         UPD_VALID   <= 1'b0;
         OVERRUN     <= 1'b0;
      end else begin
         if (CFG_LOAD)
            MOUSE_Z <= '0;
         else if (fire && WHEEL_EN != 0)
            MOUSE_Z <= satAddZ(MOUSE_Z, dz_p1);
         if (fire)
            BUTTONS <= btn_p1;
         BTN_PRESS   <= fire ? (btn_p1 & ~BUTTONS) : '0;
         BTN_RELEASE <= fire ? (~btn_p1 & BUTTONS) : '0;
         UPD_VALID   <= fire | (UPD_VALID & ~UPD_READY);
         OVERRUN     <= (fire & UPD_VALID & ~UPD_READY) | (OVERRUN & ~OVERRUN_CLR);
      end
   end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Directed bench for mouse_position_tracker with an integer reference model checked every cycle.
module tb_mouse_position_tracker;

   logic              CLK = 1'b0;
   logic              RESET = 1'b0;
   logic              PKT_VALID = 1'b0;
   logic [7:0]        PKT_STATUS = '0;
   logic [7:0]        PKT_DX = '0;
   logic [7:0]        PKT_DY = '0;
   logic [7:0]        PKT_DZ = '0;
   logic              CFG_LOAD = 1'b0;
   logic [9:0]        CFG_LIMIT_X = '0;
   logic [9:0]        CFG_LIMIT_Y = '0;
   logic              CFG_WRAP = 1'b0;
   logic [1:0]        CFG_SHIFT = '0;
   logic              CFG_INVERT_Y = 1'b0;
   logic              OVERRUN_CLR = 1'b0;
   logic              UPD_READY = 1'b0;
   logic [9:0]        MOUSE_X;
   logic [9:0]        MOUSE_Y;
   logic signed [7:0] MOUSE_Z;
   logic [2:0]        BUTTONS;
   logic [2:0]        BTN_PRESS;
   logic [2:0]        BTN_RELEASE;
   logic              UPD_VALID;
   logic              OVERRUN;

   mouse_position_tracker #(
      .POS_W(10), .DEF_LIMIT_X(640), .DEF_LIMIT_Y(480), .WHEEL_EN(1), .Z_W(8)
   ) dut (
      .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .PKT_STATUS(PKT_STATUS),
      .PKT_DX(PKT_DX), .PKT_DY(PKT_DY), .PKT_DZ(PKT_DZ), .CFG_LOAD(CFG_LOAD),
      .CFG_LIMIT_X(CFG_LIMIT_X), .CFG_LIMIT_Y(CFG_LIMIT_Y), .CFG_WRAP(CFG_WRAP),
      .CFG_SHIFT(CFG_SHIFT), .CFG_INVERT_Y(CFG_INVERT_Y), .OVERRUN_CLR(OVERRUN_CLR),
      .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_Z(MOUSE_Z), .BUTTONS(BUTTONS),
      .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE), .UPD_VALID(UPD_VALID),
      .UPD_READY(UPD_READY), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: packets become signed integer moves, applied two edges later.
   int mx = 320, my = 240, mz = 0, mlimX = 640, mlimY = 480, mshift = 0;
   int mbtn = 0, mpress = 0, mrel = 0;
   bit mwrap = 0, minv = 0, mvalid = 0, movr = 0;
   bit pv = 0, fireM = 0, setOvr = 0;
   int pdx = 0, pdy = 0, pdz = 0, pbtn = 0;

   function automatic int rawMove(input bit ovf, input bit sgn, input int b);
      if (ovf) return sgn ? -256 : 255;
      return sgn ? b - 256 : b;
   endfunction

   function automatic int fitAxis(input int s, input int lim, input bit wrap);
      int v;
      v = s;
      if (wrap) begin
         if (v < 0) v = v + lim;
         else if (v >= lim) v = v - lim;
      end
      if (v < 0) v = 0;
      if (v > lim - 1) v = lim - 1;
      return v;
   endfunction

   function automatic int satZ(input int z);
      if (z > 127) return 127;
      if (z < -128) return -128;
      return z;
   endfunction

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         mx = 320; my = 240; mz = 0; mlimX = 640; mlimY = 480;
         mwrap = 0; mshift = 0; minv = 0;
         mbtn = 0; mpress = 0; mrel = 0; mvalid = 0; movr = 0; pv = 0;
      end else begin
         fireM  = pv && !CFG_LOAD;
         setOvr = fireM && mvalid && !UPD_READY;
         mpress = 0;
         mrel   = 0;
         if (fireM) begin
            mx     = fitAxis(mx + pdx, mlimX, mwrap);
            my     = fitAxis(my + pdy, mlimY, mwrap);
            mz     = satZ(mz + pdz);
            mpress = pbtn & ~mbtn & 7;
            mrel   = mbtn & ~pbtn & 7;
            mbtn   = pbtn;
            mvalid = 1;
         end else if (UPD_READY) begin
            mvalid = 0;
         end
         movr = setOvr || (movr && !OVERRUN_CLR);
         pv   = PKT_VALID && !CFG_LOAD;
         if (PKT_VALID) begin
            pdx  = rawMove(PKT_STATUS[6], PKT_STATUS[4], int'(PKT_DX)) * (1 << mshift);
            pdy  = rawMove(PKT_STATUS[7], PKT_STATUS[5], int'(PKT_DY)) * (1 << mshift);
            if (minv) pdy = -pdy;
            pdz  = PKT_DZ[3] ? int'(PKT_DZ[3:0]) - 16 : int'(PKT_DZ[3:0]);
            pbtn = int'(PKT_STATUS[2:0]);
         end
         if (CFG_LOAD) begin
            mlimX  = (int'(CFG_LIMIT_X) < 2) ? 2 : int'(CFG_LIMIT_X);
            mlimY  = (int'(CFG_LIMIT_Y) < 2) ? 2 : int'(CFG_LIMIT_Y);
            mwrap  = CFG_WRAP;
            mshift = int'(CFG_SHIFT);
            minv   = CFG_INVERT_Y;
            mx     = mlimX / 2;
            my     = mlimY / 2;
            mz     = 0;
         end
      end
   end

   always @(negedge CLK) begin
      chk("cyc MOUSE_X", int'(MOUSE_X), mx);
      chk("cyc MOUSE_Y", int'(MOUSE_Y), my);
      chk("cyc MOUSE_Z", int'(MOUSE_Z), mz);
      chk("cyc BUTTONS", int'(BUTTONS), mbtn);
      chk("cyc BTN_PRESS", int'(BTN_PRESS), mpress);
      chk("cyc BTN_RELEASE", int'(BTN_RELEASE), mrel);
      chk("cyc UPD_VALID", int'(UPD_VALID), int'(mvalid));
      chk("cyc OVERRUN", int'(OVERRUN), int'(movr));
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic sendPkt(input logic [7:0] st, input logic [7:0] dx,
                          input logic [7:0] dy, input logic [7:0] dz);
      PKT_STATUS = st;
      PKT_DX     = dx;
      PKT_DY     = dy;
      PKT_DZ     = dz;
      PKT_VALID  = 1'b1;
      tick();
      PKT_VALID  = 1'b0;
   endtask

   task automatic cfgLoad(input int lx, input int ly, input bit w, input int sh, input bit inv);
      CFG_LIMIT_X  = 10'(lx);
      CFG_LIMIT_Y  = 10'(ly);
      CFG_WRAP     = w;
      CFG_SHIFT    = 2'(sh);
      CFG_INVERT_Y = inv;
      CFG_LOAD     = 1'b1;
      tick();
      CFG_LOAD     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      repeat (2) tick();
      chk("rst X", int'(MOUSE_X), 320);
      chk("rst Y", int'(MOUSE_Y), 240);
      chk("rst Z", int'(MOUSE_Z), 0);
      chk("rst UPD_VALID", int'(UPD_VALID), 0);
      chk("rst OVERRUN", int'(OVERRUN), 0);
      RESET = 1'b1;
      tick();

      sendPkt(8'h00, 8'd5, 8'd3, 8'h00);
      tick();
      chk("first X", int'(MOUSE_X), 325);
      chk("first Y", int'(MOUSE_Y), 243);
      chk("first UPD_VALID", int'(UPD_VALID), 1);
      UPD_READY = 1'b1;
      tick();
      chk("accept UPD_VALID", int'(UPD_VALID), 0);

      cfgLoad(640, 480, 0, 0, 0);
      chk("recentre X", int'(MOUSE_X), 320);
      sendPkt(8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      chk("clamp step1 X", int'(MOUSE_X), 64);
      sendPkt(8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      chk("clamp low X", int'(MOUSE_X), 0);
      sendPkt(8'h00, 8'd255, 8'h00, 8'h00);
      sendPkt(8'h00, 8'd255, 8'h00, 8'h00);
      sendPkt(8'h00, 8'd120, 8'h00, 8'h00);
      tick();
      chk("b2b X", int'(MOUSE_X), 630);
      sendPkt(8'h40, 8'h00, 8'h00, 8'h00);
      tick();
      chk("clamp high X", int'(MOUSE_X), 639);

      cfgLoad(160, 480, 1, 0, 0);
      chk("wrap centre X", int'(MOUSE_X), 80);
      sendPkt(8'h00, 8'd100, 8'h00, 8'h00);
      tick();
      chk("wrap high X", int'(MOUSE_X), 20);
      sendPkt(8'h10, 8'hC4, 8'h00, 8'h00);
      tick();
      chk("wrap low X", int'(MOUSE_X), 120);
      sendPkt(8'h40, 8'h00, 8'h00, 8'h00);
      tick();
      chk("wrap then clamp X", int'(MOUSE_X), 159);

      cfgLoad(640, 480, 0, 2, 1);
      sendPkt(8'h00, 8'h00, 8'd4, 8'h00);
      tick();
      chk("shift invert Y", int'(MOUSE_Y), 224);
      repeat (3) sendPkt(8'h00, 8'h00, 8'h00, 8'h0F);
      tick();
      chk("wheel Z", int'(MOUSE_Z), -3);
      repeat (17) sendPkt(8'h00, 8'h00, 8'h00, 8'h08);
      tick();
      chk("wheel sat Z", int'(MOUSE_Z), -128);
      sendPkt(8'h00, 8'h00, 8'h00, 8'h07);
      tick();
      chk("wheel recover Z", int'(MOUSE_Z), -121);

      cfgLoad(1, 0, 0, 0, 0);
      chk("min limit X", int'(MOUSE_X), 1);
      chk("min limit Y", int'(MOUSE_Y), 1);
      sendPkt(8'h00, 8'd5, 8'h00, 8'h00);
      tick();
      chk("min limit clamp X", int'(MOUSE_X), 1);

      cfgLoad(640, 480, 0, 0, 0);
      sendPkt(8'h01, 8'h00, 8'h00, 8'h00);
      tick();
      chk("btn1 BUTTONS", int'(BUTTONS), 1);
      chk("btn1 PRESS", int'(BTN_PRESS), 1);
      tick();
      chk("btn1 PRESS gone", int'(BTN_PRESS), 0);
      sendPkt(8'h03, 8'h00, 8'h00, 8'h00);
      tick();
      chk("btn2 PRESS", int'(BTN_PRESS), 2);
      sendPkt(8'h02, 8'h00, 8'h00, 8'h00);
      tick();
      chk("btn3 RELEASE", int'(BTN_RELEASE), 1);
      chk("btn3 BUTTONS", int'(BUTTONS), 2);

      cfgLoad(640, 480, 0, 0, 0);
      UPD_READY = 1'b0;
      sendPkt(8'h00, 8'd10, 8'h00, 8'h00);
      sendPkt(8'h00, 8'd10, 8'h00, 8'h00);
      tick();
      chk("ovr OVERRUN", int'(OVERRUN), 1);
      chk("ovr X", int'(MOUSE_X), 340);
      chk("ovr UPD_VALID", int'(UPD_VALID), 1);
      OVERRUN_CLR = 1'b1;
      tick();
      OVERRUN_CLR = 1'b0;
      chk("ovr clear", int'(OVERRUN), 0);
      sendPkt(8'h00, 8'd1, 8'h00, 8'h00);
      OVERRUN_CLR = 1'b1;
      tick();
      OVERRUN_CLR = 1'b0;
      chk("ovr set wins", int'(OVERRUN), 1);
      chk("ovr set X", int'(MOUSE_X), 341);
      OVERRUN_CLR = 1'b1;
      tick();
      OVERRUN_CLR = 1'b0;
      sendPkt(8'h00, 8'd1, 8'h00, 8'h00);
      UPD_READY = 1'b1;
      tick();
      chk("ready same cycle UPD_VALID", int'(UPD_VALID), 1);
      chk("ready same cycle OVERRUN", int'(OVERRUN), 0);
      tick();
      chk("ready drain UPD_VALID", int'(UPD_VALID), 0);

      UPD_READY = 1'b0;
      sendPkt(8'h00, 8'd50, 8'h00, 8'h00);
      cfgLoad(640, 480, 0, 0, 0);
      chk("flush X", int'(MOUSE_X), 320);
      tick();
      chk("flush X later", int'(MOUSE_X), 320);
      chk("flush UPD_VALID", int'(UPD_VALID), 0);
      UPD_READY = 1'b1;

      cfgLoad(160, 100, 1, 1, 0);
      chk("pre-reset X", int'(MOUSE_X), 80);
      sendPkt(8'h00, 8'd7, 8'h00, 8'h00);
      #2 RESET = 1'b0;
      #1;
      chk("async X", int'(MOUSE_X), 320);
      chk("async Y", int'(MOUSE_Y), 240);
      chk("async BUTTONS", int'(BUTTONS), 0);
      chk("async UPD_VALID", int'(UPD_VALID), 0);
      repeat (2) tick();
      RESET = 1'b1;
      repeat (2) tick();
      chk("post-reset X", int'(MOUSE_X), 320);
      chk("post-reset UPD_VALID", int'(UPD_VALID), 0);
      sendPkt(8'h00, 8'd255, 8'h00, 8'h00);
      tick();
      chk("post-reset defaults X", int'(MOUSE_X), 575);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
